// File: rtl/key_event_router.sv
// key_event_router: accepts HID key events and turns them into per-player tank keycodes
// that are latched once per frame. Define KEY_FIRE_AUTOREPEAT_EN to enable fire auto-repeat.
`timescale 1ns/1ps

module key_player #(
    parameter logic [4:0][7:0] MAP = '0   // [0]=up [1]=down [2]=left [3]=right [4]=fire
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       apply,
    input  logic [7:0] code,
    input  logic       make,
    input  logic       frame_edge,
    output logic [7:0] keycode
);
    logic [3:0] mask, hit, rest;
    logic [1:0] cur, hit_idx, rest_idx;
    logic       cur_v, fire_pending, fire_held, fire_hit;
`ifdef KEY_FIRE_AUTOREPEAT_EN
    logic [3:0] rpt_cnt;
`endif

    // rest/rest_idx: mask after dropping this key, and its highest-priority survivor
    always_comb begin
        hit      = '0;
        hit_idx  = '0;
        rest_idx = '0;
        for (int i = 0; i < 4; i++) begin
            hit[i] = (code == MAP[i]);
            if (hit[i]) hit_idx = 2'(i);
        end
        fire_hit = (code == MAP[4]);
        rest     = mask & ~hit;
        for (int i = 3; i >= 0; i--)
            if (rest[i]) rest_idx = 2'(i);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mask         <= '0;
            cur          <= '0;
            cur_v        <= 1'b0;
            fire_pending <= 1'b0;
            fire_held    <= 1'b0;
            keycode      <= 8'h00;
`ifdef KEY_FIRE_AUTOREPEAT_EN
            rpt_cnt      <= '0;
`endif
        end else begin
            // Output is sampled from pre-event state; an event landing on the edge waits a frame
            if (frame_edge) begin
                if (fire_pending)  keycode <= MAP[4];
                else if (cur_v)    keycode <= MAP[{1'b0, cur}];
                else               keycode <= 8'h00;
                fire_pending <= 1'b0;
`ifdef KEY_FIRE_AUTOREPEAT_EN
                if (fire_held) begin
                    rpt_cnt <= rpt_cnt + 4'd1;
                    if (rpt_cnt == 4'hF) fire_pending <= 1'b1;
                end
`endif
            end
            if (apply) begin
                if (fire_hit) begin
                    fire_held <= make;
                    if (make) fire_pending <= 1'b1;
`ifdef KEY_FIRE_AUTOREPEAT_EN
                    if (!make) rpt_cnt <= '0;
`endif
                end else if (|hit) begin
                    if (make) begin
                        mask  <= mask | hit;
                        cur   <= hit_idx;
                        cur_v <= 1'b1;
                    end else if (|(mask & hit)) begin
                        mask <= rest;
                        if (cur_v && cur == hit_idx) begin
                            cur_v <= |rest;
                            cur   <= rest_idx;
                        end
                    end
                end
            end
        end
    end
endmodule

module key_event_router (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [7:0] ev_code,
    input  logic       ev_make,
    output logic [7:0] keycode_p0,
    output logic [7:0] keycode_p1
);
    localparam int NUM_PLAYERS = 2;
    // Per player, fire..up from MSB to LSB; player 1 in the upper half
    localparam logic [NUM_PLAYERS-1:0][4:0][7:0] KEY_MAP =
        {8'h28, 8'h4F, 8'h50, 8'h51, 8'h52,
         8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A};

    typedef enum logic {IDLE, UPDATE} state_t;
    state_t state, state_nxt;

    logic [1:0]                  frame_sync;
    logic                        frame_edge, apply, cap_make;
    logic [7:0]                  cap_code;
    logic [NUM_PLAYERS-1:0][7:0] keycode;

    assign frame_edge = frame_sync[0] & ~frame_sync[1];
    assign apply      = (state == UPDATE);
    assign keycode_p0 = keycode[0];
    assign keycode_p1 = keycode[1];

    always_ff @(posedge Clk) begin
        if (Reset) frame_sync <= '0;
        else       frame_sync <= {frame_sync[0], frame_clk};
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (ev_valid && ev_ready) begin
            cap_code <= ev_code;
            cap_make <= ev_make;
        end
    end

    always_comb begin
        state_nxt = state;
        ev_ready  = 1'b0;
        case (state)
            IDLE: begin
                ev_ready = !Reset;
                if (ev_valid && ev_ready) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        key_player #(.MAP(KEY_MAP[p])) u_player (
            .Clk        (Clk),
            .Reset      (Reset),
            .apply      (apply),
            .code       (cap_code),
            .make       (cap_make),
            .frame_edge (frame_edge),
            .keycode    (keycode[p])
        );
    end
endmodule

// File: tb/tb_key_event_router.sv
// Scoreboard bench for key_event_router: a frame-level player model predicts the keycodes
// shown after each frame strobe; a monitor checks the DUT outputs every cycle.
`timescale 1ns/1ps

module tb_key_event_router;
    logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, ev_valid = 1'b0, ev_make = 1'b0;
    logic       ev_ready;
    logic [7:0] ev_code = 8'h00, keycode_p0, keycode_p1;
    int         checks = 0, errors = 0;

    always #10 Clk = ~Clk;

    key_event_router dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_make    (ev_make),
        .keycode_p0 (keycode_p0),
        .keycode_p1 (keycode_p1)
    );

    // Reference model: keys per player in order up, down, left, right, fire
    logic [7:0]  MAPS [2][5] = '{'{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C},
                                '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h28}};
    bit          held [2][4];
    int          cur  [2];
    bit          pend [2];
    bit          fheld[2];
    int          rcnt [2];
    logic [15:0] exp_q[$];
    logic [15:0] cur_exp = 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) held[p][k] = 1'b0;
            cur[p] = -1; pend[p] = 1'b0; fheld[p] = 1'b0; rcnt[p] = 0;
        end
    endfunction

    function automatic void model_apply(input logic [7:0] c, input logic m);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 5; k++)
                if (c == MAPS[p][k]) begin
                    if (k == 4) begin
                        fheld[p] = m;
                        if (m) pend[p] = 1'b1;
                        else   rcnt[p] = 0;
                    end else if (m) begin
                        held[p][k] = 1'b1;
                        cur[p] = k;
                    end else if (held[p][k]) begin
                        held[p][k] = 1'b0;
                        if (cur[p] == k) begin
                            cur[p] = -1;
                            for (int j = 3; j >= 0; j--) if (held[p][j]) cur[p] = j;
                        end
                    end
                end
    endfunction

    function automatic logic [15:0] model_edge();
        logic [7:0] kc[2];
        for (int p = 0; p < 2; p++) begin
            if (pend[p])         kc[p] = MAPS[p][4];
            else if (cur[p] >= 0) kc[p] = MAPS[p][cur[p]];
            else                 kc[p] = 8'h00;
            pend[p] = 1'b0;
`ifdef KEY_FIRE_AUTOREPEAT_EN
            if (fheld[p]) begin
                rcnt[p]++;
                if (rcnt[p] == 16) begin pend[p] = 1'b1; rcnt[p] = 0; end
            end
`endif
        end
        return {kc[1], kc[0]};
    endfunction

    // Monitor: new keycodes appear two negedges after the strobe is first seen high
    initial begin
        logic prev_fc;
        int   pend_n;
        prev_fc = 1'b0;
        pend_n  = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                cur_exp = 16'h0000;
                pend_n  = 0;
                prev_fc = frame_clk;
            end else begin
                if (frame_clk && !prev_fc) pend_n = 2;
                else if (pend_n > 0) begin
                    pend_n--;
                    if (pend_n == 0) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL scoreboard_underflow: output update with no expectation at %0t", $time);
                        end else cur_exp = exp_q.pop_front();
                    end
                end
                prev_fc = frame_clk;
                check("keycode_p1_p0", {keycode_p1, keycode_p0}, cur_exp);
            end
        end
    end

    task automatic frame();
        frame_clk = 1'b1;
        exp_q.push_back(model_edge());
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic m);
        int budget = 8;
        bit done = 1'b0;
        bit ok   = 1'b0;
        ev_code = c; ev_make = m; ev_valid = 1'b1;
        while (!done) begin
            @(negedge Clk);
            if (ev_ready) begin done = 1'b1; ok = 1'b1; end
            else begin
                budget--;
                if (budget == 0) begin
                    checks++; errors++; done = 1'b1;
                    $display("FAIL send_timeout: ev_ready stayed 0 expected 1 at %0t", $time);
                end
            end
            @(posedge Clk);
            #1;
        end
        ev_valid = 1'b0;
        if (ok) model_apply(c, m);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq;
        logic [7:0] b2b_code[4] = '{8'h4F, 8'h16, 8'h50, 8'h16};
        logic       b2b_make[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int         idx, n, budget;
        logic [7:0] c;

        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_ev_ready", ev_ready, 1'b0);
        check("reset_keycode_p0", keycode_p0, 8'h00);
        check("reset_keycode_p1", keycode_p1, 8'h00);
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("ready_after_reset", ev_ready, 1'b1);
        @(posedge Clk);
        #1;

        // Single motion press held across frames
        send(8'h1A, 1'b1); frame(); frame();
        send(8'h1A, 1'b0); frame();
        // Newest press wins; releasing it falls back to the held key
        send(8'h04, 1'b1); frame();
        send(8'h07, 1'b1); frame();
        send(8'h07, 1'b0); frame();
        send(8'h04, 1'b0); frame();
        // Tap fire while holding a motion key: one fire frame, then motion again
        send(8'h52, 1'b1); frame();
        send(8'h28, 1'b1); send(8'h28, 1'b0); frame(); frame();
        send(8'h52, 1'b0); frame();

        // Back-to-back events with ev_valid held high
        ev_valid = 1'b1; idx = 0; n = 0; seq = '0; budget = 20;
        ev_code = b2b_code[0]; ev_make = b2b_make[0];
        while (idx < 4 && budget > 0) begin
            @(negedge Clk);
            if (n < 4) begin seq[n] = ev_ready; n++; end
            budget--;
            if (ev_ready) begin
                model_apply(b2b_code[idx], b2b_make[idx]);
                idx++;
                @(posedge Clk);
                #1;
                if (idx < 4) begin ev_code = b2b_code[idx]; ev_make = b2b_make[idx]; end
            end else begin
                @(posedge Clk);
                #1;
            end
        end
        ev_valid = 1'b0;
        check("b2b_ready_pattern", seq, 4'b0101);
        check("b2b_events_taken", 16'(idx), 16'd4);
        @(posedge Clk);
        #1;
        frame();
        send(8'h4F, 1'b0); send(8'h50, 1'b0); frame();

        // Fire held for 40 frames
        send(8'h2C, 1'b1);
        repeat (40) frame();
        send(8'h2C, 1'b0); frame();

        // Reset while the captured press is being applied
        ev_code = 8'h16; ev_make = 1'b1; ev_valid = 1'b1;
        @(negedge Clk);
        check("pre_reset_ready", ev_ready, 1'b1);
        @(posedge Clk);
        #1 ev_valid = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        check("ready_during_reset", ev_ready, 1'b0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        check("ready_after_midreset", ev_ready, 1'b1);
        @(posedge Clk);
        #1;
        frame();

        // Random traffic, mostly mapped codes with some strays
        for (int f = 0; f < 200; f++) begin
            n = $urandom_range(0, 3);
            for (int e = 0; e < n; e++) begin
                if ($urandom_range(0, 9) < 9) c = MAPS[$urandom_range(0, 1)][$urandom_range(0, 4)];
                else                          c = 8'($urandom);
                send(c, 1'($urandom_range(0, 1)));
            end
            frame();
        end

        repeat (4) @(posedge Clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_event_router.md
KEY_EVENT_ROUTER -- requirements
Module: key_event_router

Interface
REQ-001 Clk  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 frame_clk  input  1  frame strobe, about 60 Hz, asynchronous to Clk in phase.
REQ-004 ev_valid  input  1  key event offered this cycle.
REQ-005 ev_ready  output  1  router can accept an event this cycle.
REQ-006 ev_code  input  8  USB HID usage code of the event.
REQ-007 ev_make  input  1  1 = key press, 0 = key release.
REQ-008 keycode_p0  output  8  player-0 keycode to tank controller; one of 1A/16/04/07/2C/00.
REQ-009 keycode_p1  output  8  player-1 keycode to tank controller; one of 52/51/50/4F/28/00.

Function
REQ-010 An event SHALL transfer only on a cycle where ev_valid and ev_ready are both 1.
REQ-011 The FSM SHALL have two states: IDLE, with ev_ready=1, and UPDATE, with ev_ready=0.
REQ-012 On transfer the FSM SHALL capture ev_code and ev_make and go IDLE->UPDATE.
REQ-013 UPDATE SHALL apply the captured event to per-player state, then return to IDLE next cycle; maximum throughput is 1 event per 2 cycles.
REQ-014 Player-0 key map: up 1A, down 16, left 04, right 07, fire 2C.
REQ-015 Player-1 key map: up 52, down 51, left 50, right 4F, fire 28.
REQ-016 Any other code SHALL be accepted and discarded, with no state change.
REQ-017 Per player, the router SHALL hold a 4-bit held-motion mask plus a "current" motion key.
REQ-018 Motion press: set the mask bit and make that key current, including when the bit was already set.
REQ-019 Motion release of the current key: clear its bit; the new current is the highest-priority held key (up>down>left>right), or none if the mask is empty.
REQ-020 Motion release of a non-current key: clear its bit only.
REQ-021 Release of a key not held: no effect.
REQ-022 Fire press: set fire_pending and fire_held.
REQ-023 Fire release: clear fire_held only.
REQ-024 frame_clk rising edge SHALL be detected with a 2-register delay; the edge pulse is 1 Clk wide.
REQ-025 keycode_pX SHALL change only on the cycle following an edge pulse and SHALL hold for the whole frame.
REQ-026 At an edge with fire_pending=1: output the player fire code for that frame and clear fire_pending.
REQ-027 At an edge otherwise: output the current motion code, or 00 if none.
REQ-028 An event applied in the same cycle as the edge pulse SHALL take effect at the next edge.
REQ-029 Players SHALL be fully independent; a player-1 event never alters player-0 state.
REQ-030 A fire press while fire output is already showing SHALL set pending again, so fire is shown at the next edge as well.

Reset
REQ-031 While Reset=1: ev_ready=0, FSM=IDLE, masks=0, current=none, fire_pending=0, fire_held=0, keycode_p0=00, keycode_p1=00, frame delay regs=0.
REQ-032 Reset mid-UPDATE SHALL discard the captured event.
REQ-033 ev_ready=1 on the first cycle after Reset deasserts.

Configuration
REQ-034 Macro KEY_FIRE_AUTOREPEAT_EN SHALL gate fire auto-repeat.
REQ-035 KEY_FIRE_AUTOREPEAT_EN defined: while fire_held=1, a per-player 4-bit frame counter SHALL re-set fire_pending every 16th edge after the initial fire frame; the counter clears on fire release and on Reset.
REQ-036 KEY_FIRE_AUTOREPEAT_EN undefined: exactly one fire frame per press, and no counter logic is present.

Verification
REQ-037 Press 1A, then 2 edges -> keycode_p0=1A after the first edge, keycode_p1=00 throughout.
REQ-038 Press 04, press 07, release 07, with edges between -> keycode_p0 goes 04, 07, 04.
REQ-039 Hold 52, press and release 28 within one frame -> keycode_p1 reads 28 for exactly one frame, then 52.
REQ-040 ev_valid held at 1 with 4 back-to-back events -> ev_ready toggles 1,0,1,0; all 4 events are applied.
REQ-041 Reset asserted in UPDATE with 16 press captured -> keycode_p0=00 after the next edge; ev_ready=1 one cycle after Reset drops.
REQ-042 Build with KEY_FIRE_AUTOREPEAT_EN, hold 2C for 40 edges -> fire frames at edges 1, 17 and 33 only; build without it -> edge 1 only.
